// File: rtl/maxpool_l1_if.sv
// Handshake and shared memory-port bundle between the pooling stage and its environment.
// The pooling engine masters the memory port; the slave view belongs to memory/control.
interface maxpool_l1_if #(
    parameter int AW = 12,
    parameter int DW = 20
);
    logic          start;
    logic          busy;
    logic          done;
    logic          crd;
    logic [AW-1:0] caddr_rd;
    logic [DW-1:0] cdata_rd;
    logic          cwr;
    logic [AW-1:0] caddr_wr;
    logic [DW-1:0] cdata_wr;
    logic [2:0]    csel;

    modport master (
        input  start, cdata_rd,
        output busy, done, crd, caddr_rd, cwr, caddr_wr, cdata_wr, csel
    );

    modport slave (
        output start, cdata_rd,
        input  busy, done, crd, caddr_rd, cwr, caddr_wr, cdata_wr, csel
    );
endinterface

// File: rtl/maxpool_l1.sv
// 2x2 stride-2 signed max-pooling of the L0 map into L1 memory over a shared
// read/write port; one output word every six cycles, no back-pressure.
module maxpool_l1 #(
    parameter int         IN_W   = 64,
    parameter int         DW     = 20,
    parameter int         AW     = 12,
    parameter logic [2:0] SEL_RD = 3'b001,
    parameter logic [2:0] SEL_WR = 3'b011
) (
    input  logic         clk,
    input  logic         reset,
    maxpool_l1_if.master bus
);

    localparam int LOG_IN = $clog2(IN_W);
    localparam int OW     = LOG_IN - 1;
    localparam logic [OW-1:0] COORD_LAST = OW'(IN_W / 2 - 1);
    localparam logic [OW-1:0] COORD_ONE  = OW'(1'b1);
    localparam logic [OW-1:0] COORD_ZERO = OW'(1'b0);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_LAST  = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    // Row 2r+k[1], column 2c+k[0]; IN_W is a power of two so r*IN_W+c is a concatenation.
    function automatic logic [AW-1:0] rd_addr(input logic [OW-1:0] r,
                                              input logic [OW-1:0] c,
                                              input logic [1:0]    k);
        return AW'({r, k[1], c, k[0]});
    endfunction

    // Signed compare; a tie keeps the held value.
    function automatic logic [DW-1:0] smax(input logic [DW-1:0] cand,
                                           input logic [DW-1:0] held);
        return ($signed(cand) > $signed(held)) ? cand : held;
    endfunction

    state_e        state_q, state_d;
    logic [1:0]    k_q, k_d;
    logic [OW-1:0] r_q, r_d;
    logic [OW-1:0] c_q, c_d;
    logic [DW-1:0] max_q, max_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          crd_q, crd_d;
    logic [AW-1:0] caddr_rd_q, caddr_rd_d;
    logic          cwr_q, cwr_d;
    logic [AW-1:0] caddr_wr_q, caddr_wr_d;
    logic [DW-1:0] cdata_wr_q, cdata_wr_d;
    logic [2:0]    csel_q, csel_d;

    logic          last_win_s;
    logic [OW-1:0] r_nxt_s;
    logic [OW-1:0] c_nxt_s;
    logic [DW-1:0] pool_s;

    assign last_win_s = (r_q == COORD_LAST) && (c_q == COORD_LAST);
    assign pool_s     = smax(bus.cdata_rd, max_q);

    // Raster advance of the window coordinates.
    always_comb begin
        r_nxt_s = r_q;
        c_nxt_s = c_q + COORD_ONE;
        if (c_q == COORD_LAST) begin
            r_nxt_s = r_q + COORD_ONE;
            c_nxt_s = COORD_ZERO;
        end else begin
            r_nxt_s = r_q;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) state_d = ST_READ;
                else           state_d = ST_IDLE;
            end
            ST_READ: begin
                if (k_q == 2'd3) state_d = ST_LAST;
                else             state_d = ST_READ;
            end
            ST_LAST:  state_d = ST_WRITE;
            ST_WRITE: begin
                if (last_win_s) state_d = ST_DONE;
                else            state_d = ST_READ;
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Output and datapath next values; every port is taken straight from a flop.
    always_comb begin
        k_d        = k_q;
        r_d        = r_q;
        c_d        = c_q;
        max_d      = max_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        crd_d      = crd_q;
        caddr_rd_d = caddr_rd_q;
        cwr_d      = cwr_q;
        caddr_wr_d = caddr_wr_q;
        cdata_wr_d = cdata_wr_q;
        csel_d     = csel_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    busy_d     = 1'b1;
                    crd_d      = 1'b1;
                    csel_d     = SEL_RD;
                    k_d        = 2'd0;
                    r_d        = COORD_ZERO;
                    c_d        = COORD_ZERO;
                    caddr_rd_d = rd_addr(COORD_ZERO, COORD_ZERO, 2'd0);
                end else begin
                    busy_d = 1'b0;
                end
            end
            ST_READ: begin
                k_d = k_q + 2'd1;
                if (k_q == 2'd3) begin
                    crd_d = 1'b0;
                end else begin
                    caddr_rd_d = rd_addr(r_q, c_q, k_q + 2'd1);
                end
                // Datum k-1 arrives during READ k; datum 0 seeds the running max.
                if (k_q == 2'd1) begin
                    max_d = bus.cdata_rd;
                end else if (k_q != 2'd0) begin
                    max_d = pool_s;
                end else begin
                    max_d = max_q;
                end
            end
            ST_LAST: begin
                max_d      = pool_s;
                cwr_d      = 1'b1;
                csel_d     = SEL_WR;
                caddr_wr_d = AW'({r_q, c_q});
                cdata_wr_d = pool_s;
            end
            ST_WRITE: begin
                cwr_d = 1'b0;
                if (last_win_s) begin
                    busy_d = 1'b0;
                    done_d = 1'b1;
                    csel_d = 3'b000;
                    r_d    = COORD_ZERO;
                    c_d    = COORD_ZERO;
                end else begin
                    r_d        = r_nxt_s;
                    c_d        = c_nxt_s;
                    k_d        = 2'd0;
                    crd_d      = 1'b1;
                    csel_d     = SEL_RD;
                    caddr_rd_d = rd_addr(r_nxt_s, c_nxt_s, 2'd0);
                end
            end
            ST_DONE: begin
                done_d = 1'b0;
            end
            default: begin
                k_d    = 2'd0;
                r_d    = COORD_ZERO;
                c_d    = COORD_ZERO;
                busy_d = 1'b0;
                crd_d  = 1'b0;
                cwr_d  = 1'b0;
                csel_d = 3'b000;
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            k_q        <= 2'd0;
            r_q        <= COORD_ZERO;
            c_q        <= COORD_ZERO;
            max_q      <= {DW{1'b0}};
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            crd_q      <= 1'b0;
            caddr_rd_q <= {AW{1'b0}};
            cwr_q      <= 1'b0;
            caddr_wr_q <= {AW{1'b0}};
            cdata_wr_q <= {DW{1'b0}};
            csel_q     <= 3'b000;
        end else begin
            k_q        <= k_d;
            r_q        <= r_d;
            c_q        <= c_d;
            max_q      <= max_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            crd_q      <= crd_d;
            caddr_rd_q <= caddr_rd_d;
            cwr_q      <= cwr_d;
            caddr_wr_q <= caddr_wr_d;
            cdata_wr_q <= cdata_wr_d;
            csel_q     <= csel_d;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.crd      = crd_q;
    assign bus.caddr_rd = caddr_rd_q;
    assign bus.cwr      = cwr_q;
    assign bus.caddr_wr = caddr_wr_q;
    assign bus.cdata_wr = cdata_wr_q;
    assign bus.csel     = csel_q;

endmodule
